reg_scoreboard_tagged: RTL and testbench
========================================

Name: reg_scoreboard_tagged

Overview:
- Parametrised multi-port register scoreboard; generalises the single-port toggle scoreboard.
- Each entry holds a busy bit plus the tag of its in-flight producer.
- Issue marks the destination busy and records the tag. Writeback clears busy only on tag match, so a stale completion cannot unblock a newer producer.
- Sits between decode/issue and the writeback buses. Read ports feed the issue-stall and operand-source logic.

Parameters:
- NUM_ENTRIES, 32, number of architectural registers tracked; power of two, >= 2.
- NUM_READ, 2, number of combinational lookup ports.
- NUM_WB, 2, number of writeback/clear ports.
- TAG_W, 4, producer tag width.
- ZERO_REG, 1, when 1, entry 0 is never busy and ignores issue.
- (derived) IDX_W = $clog2(NUM_ENTRIES); CNT_W = $clog2(NUM_ENTRIES+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  clears all busy bits next edge.
- r_index  in  NUM_READ*IDX_W  lookup indices, port p at [p*IDX_W +: IDX_W].
- r_busy  out  NUM_READ  busy bit of each looked-up entry.
- r_tag  out  NUM_READ*TAG_W  stored producer tag of each looked-up entry.
- iss_en  in  1  issue valid.
- iss_index  in  IDX_W  destination register being issued.
- iss_tag  in  TAG_W  tag of the new producer.
- wb_en  in  NUM_WB  per-port writeback valid.
- wb_index  in  NUM_WB*IDX_W  writeback destination per port.
- wb_tag  in  NUM_WB*TAG_W  completing producer tag per port.
- busy_count  out  CNT_W  registered count of busy entries.
- all_clear  out  1  registered; 1 when busy_count==0.

Behaviour:
- Reset (sync, active-high, takes priority over everything):
  - all busy=0, all tags=0.
  - busy_count=0, all_clear=1.
  - rst mid-operation discards any same-cycle issue/wb.
- Priority per edge, highest first: rst, then flush, then issue, then writeback.
- flush (no rst):
  - all busy=0; tags retained.
  - same-cycle issue and wb ignored.
  - busy_count=0, all_clear=1 next cycle.
- Writeback, port w with wb_en[w]=1:
  - If entry wb_index is busy and stored tag == wb_tag, busy <= 0.
  - Tag mismatch or entry not busy: no effect.
  - Multiple ports may clear distinct entries in the same cycle.
  - Two ports naming the same entry: cleared if either matches.
- Issue, iss_en=1:
  - busy[iss_index] <= 1, tag[iss_index] <= iss_tag.
  - Issue to an already-busy entry overwrites the tag (WAW: newest producer owns the entry).
  - Same-cycle issue and wb to the same index: issue wins; entry ends busy with iss_tag, even if wb tag matched the old producer.
- ZERO_REG=1:
  - Issue to index 0 ignored.
  - r_busy for index 0 always 0; r_tag for index 0 reads 0.
- Read ports (combinational, zero latency):
  - Reflect registered state with writeback bypass: if a same-cycle wb would clear the entry (enabled, busy, tag match), r_busy=0.
  - Same-cycle issue is NOT bypassed; the reader sees the pre-issue value.
  - r_tag always returns the stored tag, with no bypass.
  - r_tag is meaningful only when the registered busy bit is 1.
- busy_count / all_clear:
  - Registered; equal to the popcount of the busy vector after the current edge's update. Valid the cycle after the update.
  - Computed from next-state popcount or incremental delta; must never drift.
- Width rules:
  - Indices are IDX_W wide, so no out-of-range index exists.
  - busy_count saturates naturally at NUM_ENTRIES (CNT_W wide).
- X-safety: iss_index/iss_tag ignored when iss_en=0; wb_index/wb_tag per port ignored when wb_en[w]=0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> r_busy=0 on all ports for all indices, busy_count=0, all_clear=1.
- Issue/clear: issue idx 5 tag 3; next cycle r_index0=5 -> r_busy[0]=1, r_tag=3, busy_count=1; wb idx 5 tag 3 -> r_busy[0]=0 same cycle (bypass), busy_count=0 next cycle.
- Stale wb (WAW): issue idx 7 tag 1, then issue idx 7 tag 2; wb idx 7 tag 1 -> r_busy stays 1, tag 2; wb idx 7 tag 2 -> cleared.
- Simultaneous events:
  - Same cycle: issue idx 9 tag 4 and wb idx 9 matching old tag 6 -> entry busy with tag 4.
  - Two wb ports clearing idx 2 and idx 3 together -> both clear, busy_count drops by 2.
- Zero register and flush:
  - Issue idx 0 -> r_busy=0, busy_count unchanged.
  - Fill idx 1..31; busy_count=31 (NUM_ENTRIES-1 with ZERO_REG=1), all_clear=0.
  - Assert flush together with an issue to idx 4 -> all busy=0, busy_count=0, all_clear=1 next cycle.
- Reset mid-operation: 10 entries busy, rst asserted together with iss_en and wb_en -> all cleared, busy_count=0; the first post-reset issue behaves normally.

Source files
------------

// File: rtl/reg_scoreboard_tagged_if.sv
// Issue/writeback/lookup bundle for the tagged register scoreboard.
// master drives issue, writeback and lookup indices; slave returns state.
interface reg_scoreboard_tagged_if #(
    parameter int NUM_ENTRIES = 32,
    parameter int NUM_READ    = 2,
    parameter int NUM_WB      = 2,
    parameter int TAG_W       = 4
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic                      flush;
    logic [NUM_READ*IDX_W-1:0] r_index;
    logic [NUM_READ-1:0]       r_busy;
    logic [NUM_READ*TAG_W-1:0] r_tag;
    logic                      iss_en;
    logic [IDX_W-1:0]          iss_index;
    logic [TAG_W-1:0]          iss_tag;
    logic [NUM_WB-1:0]         wb_en;
    logic [NUM_WB*IDX_W-1:0]   wb_index;
    logic [NUM_WB*TAG_W-1:0]   wb_tag;
    logic [CNT_W-1:0]          busy_count;
    logic                      all_clear;

    modport master (
        output flush, r_index, iss_en, iss_index, iss_tag, wb_en, wb_index, wb_tag,
        input  r_busy, r_tag, busy_count, all_clear
    );

    modport slave (
        input  flush, r_index, iss_en, iss_index, iss_tag, wb_en, wb_index, wb_tag,
        output r_busy, r_tag, busy_count, all_clear
    );
endinterface

// File: rtl/reg_scoreboard_tagged.sv
// Multi-port register scoreboard: per-entry busy bit plus in-flight producer tag.
// Writeback clears only on tag match so stale completions never unblock a newer producer.
module reg_scoreboard_tagged #(
    parameter int NUM_ENTRIES = 32,
    parameter int NUM_READ    = 2,
    parameter int NUM_WB      = 2,
    parameter int TAG_W       = 4,
    parameter int ZERO_REG    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_scoreboard_tagged_if.slave sb
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0]            busy;
    logic [NUM_ENTRIES-1:0]            busy_nxt;
    logic [NUM_ENTRIES-1:0]            wb_clr;
    logic [NUM_ENTRIES-1:0][TAG_W-1:0] tag;
    logic [CNT_W-1:0]                  cnt_nxt;
    logic [CNT_W-1:0]                  busy_count;
    logic                              all_clear;
    logic                              iss_ok;
    logic [NUM_READ-1:0]               rd_busy;
    logic [NUM_READ*TAG_W-1:0]         rd_tag;

    // An entry is cleared if any enabled port names it with the current producer's tag.
    always_comb begin
        wb_clr = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            for (int w = 0; w < NUM_WB; w++) begin
                if (sb.wb_en[w] && sb.wb_index[w*IDX_W +: IDX_W] == IDX_W'(e) &&
                    busy[e] && tag[e] == sb.wb_tag[w*TAG_W +: TAG_W])
                    wb_clr[e] = 1'b1;
            end
        end
    end

    assign iss_ok = sb.iss_en && !(ZERO_REG != 0 && sb.iss_index == '0);

    // Issue is applied after writeback so it wins on a same-index collision.
    always_comb begin
        busy_nxt = busy & ~wb_clr;
        if (iss_ok)
            busy_nxt[sb.iss_index] = 1'b1;
        if (sb.flush)
            busy_nxt = '0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int e = 0; e < NUM_ENTRIES; e++)
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[e]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            tag        <= '0;
            busy_count <= '0;
            all_clear  <= 1'b1;
        end else begin
            busy <= busy_nxt;
            if (iss_ok && !sb.flush)
                tag[sb.iss_index] <= sb.iss_tag;
            busy_count <= cnt_nxt;
            all_clear  <= (cnt_nxt == '0);
        end
    end

    // Lookups bypass same-cycle writeback clears but not same-cycle issue.
    always_comb begin
        rd_busy = '0;
        rd_tag  = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (!(ZERO_REG != 0 && sb.r_index[p*IDX_W +: IDX_W] == '0)) begin
                rd_busy[p] = busy[sb.r_index[p*IDX_W +: IDX_W]] &
                             ~wb_clr[sb.r_index[p*IDX_W +: IDX_W]];
                rd_tag[p*TAG_W +: TAG_W] = tag[sb.r_index[p*IDX_W +: IDX_W]];
            end
        end
    end

    assign sb.r_busy     = rd_busy;
    assign sb.r_tag      = rd_tag;
    assign sb.busy_count = busy_count;
    assign sb.all_clear  = all_clear;
endmodule

// File: tb/tb_reg_scoreboard_tagged.sv
// Directed bench for reg_scoreboard_tagged; stimulus queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_reg_scoreboard_tagged;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    reg_scoreboard_tagged_if sb ();

    reg_scoreboard_tagged dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_rd;
        logic [1:0]  rb;
        bit          chk_rt;
        logic [3:0]  rt;
        bit          chk_cnt;
        logic [5:0]  cnt;
        logic        ac;
    } exp_t;

    exp_t q[$];
    exp_t e;

    task automatic chk(string n, logic [31:0] act, logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", n, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                chk({e.name, "_missed"}, 32'(cyc), 32'(e.cyc));
            end else begin
                if (e.chk_rd)  chk({e.name, "_r_busy"}, 32'(sb.r_busy), 32'(e.rb));
                if (e.chk_rt)  chk({e.name, "_r_tag0"}, 32'(sb.r_tag[3:0]), 32'(e.rt));
                if (e.chk_cnt) begin
                    chk({e.name, "_busy_count"}, 32'(sb.busy_count), 32'(e.cnt));
                    chk({e.name, "_all_clear"}, 32'(sb.all_clear), 32'(e.ac));
                end
            end
        end
    end

    task automatic exp_rd(string n, logic [1:0] rb, bit chk_rt, logic [3:0] rt);
        exp_t x;
        x = '{cyc: cyc, name: n, chk_rd: 1'b1, rb: rb, chk_rt: chk_rt, rt: rt,
              chk_cnt: 1'b0, cnt: 6'd0, ac: 1'b0};
        q.push_back(x);
    endtask

    task automatic exp_cnt(string n, logic [5:0] cnt, logic ac);
        exp_t x;
        x = '{cyc: cyc, name: n, chk_rd: 1'b0, rb: 2'b00, chk_rt: 1'b0, rt: 4'd0,
              chk_cnt: 1'b1, cnt: cnt, ac: ac};
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb.flush  = 1'b0;
        sb.iss_en = 1'b0;
        sb.wb_en  = 2'b00;
    endtask

    task automatic rd(int a, int b);
        sb.r_index = {5'(b), 5'(a)};
    endtask

    task automatic issue(int idx, int t);
        sb.iss_en    = 1'b1;
        sb.iss_index = 5'(idx);
        sb.iss_tag   = 4'(t);
    endtask

    task automatic wb(int p, int idx, int t);
        sb.wb_en[p]          = 1'b1;
        sb.wb_index[p*5 +: 5] = 5'(idx);
        sb.wb_tag[p*4 +: 4]   = 4'(t);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        sb.iss_index = '0;
        sb.iss_tag   = '0;
        sb.wb_index  = '0;
        sb.wb_tag    = '0;
        rd(0, 0);
        step();
        exp_cnt("rst_state", 6'd0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            rd(i, 31 - i);
            exp_rd("rst_rd", 2'b00, 1'b0, 4'd0);
            step();
        end

        // issue then matching writeback with bypass
        rst = 1'b0;
        issue(5, 3); step();
        idle(); rd(5, 0); exp_rd("iss_rd", 2'b01, 1'b1, 4'd3); exp_cnt("iss_cnt", 6'd1, 1'b0); step();
        idle(); rd(5, 0); wb(0, 5, 3); exp_rd("wb_bypass", 2'b00, 1'b1, 4'd3); step();
        idle(); rd(5, 0); exp_rd("wb_clr", 2'b00, 1'b0, 4'd0); exp_cnt("wb_cnt", 6'd0, 1'b1);

        // stale writeback after WAW re-issue
        issue(7, 1); step();
        idle(); issue(7, 2); step();
        idle(); rd(7, 0); wb(0, 7, 1); exp_rd("stale_wb", 2'b01, 1'b1, 4'd2); exp_cnt("waw_cnt", 6'd1, 1'b0); step();
        idle(); rd(7, 0); exp_rd("stale_kept", 2'b01, 1'b1, 4'd2); exp_cnt("stale_cnt", 6'd1, 1'b0); step();
        idle(); rd(7, 0); wb(1, 7, 2); exp_rd("waw_bypass", 2'b00, 1'b1, 4'd2); step();
        idle(); rd(7, 0); exp_rd("waw_clr", 2'b00, 1'b0, 4'd0); exp_cnt("waw_clr_cnt", 6'd0, 1'b1);

        // issue and matching wb on the same index in one cycle
        issue(9, 6); step();
        idle(); rd(9, 0); issue(9, 4); wb(1, 9, 6); exp_rd("iss_wb_rd", 2'b00, 1'b1, 4'd6); step();
        idle(); rd(9, 0); exp_rd("iss_wins", 2'b01, 1'b1, 4'd4); exp_cnt("iss_wins_cnt", 6'd1, 1'b0); step();
        idle(); wb(0, 9, 4); step();
        idle(); exp_cnt("iss_wins_clr", 6'd0, 1'b1);

        // two ports clearing distinct entries
        issue(2, 1); step();
        idle(); issue(3, 2); step();
        idle(); rd(2, 3); exp_rd("two_pre", 2'b11, 1'b1, 4'd1); exp_cnt("two_pre_cnt", 6'd2, 1'b0); step();
        idle(); rd(2, 3); wb(0, 2, 1); wb(1, 3, 2); exp_rd("two_bypass", 2'b00, 1'b0, 4'd0); step();
        idle(); rd(2, 3); exp_rd("two_clr", 2'b00, 1'b0, 4'd0); exp_cnt("two_cnt", 6'd0, 1'b1);

        // zero register
        issue(0, 5); step();
        idle(); rd(0, 0); exp_rd("zero_rd", 2'b00, 1'b1, 4'd0); exp_cnt("zero_cnt", 6'd0, 1'b1);

        // fill every writable entry, then flush against a same-cycle issue
        for (int i = 1; i < 32; i++) begin
            idle(); issue(i, i); step();
        end
        idle(); rd(31, 0); exp_rd("fill_rd", 2'b01, 1'b1, 4'd15); exp_cnt("fill_cnt", 6'd31, 1'b0);
        sb.flush = 1'b1; issue(4, 9); step();
        idle(); rd(4, 0); exp_rd("flush_rd", 2'b00, 1'b1, 4'd4); exp_cnt("flush_cnt", 6'd0, 1'b1);

        // reset in the middle of traffic
        for (int i = 10; i < 20; i++) begin
            idle(); issue(i, i); step();
        end
        idle(); exp_cnt("mid_cnt", 6'd10, 1'b0);
        rst = 1'b1; issue(20, 3); wb(0, 10, 10); step();
        idle(); rst = 1'b0; rd(20, 10);
        exp_rd("rst_mid_rd", 2'b00, 1'b1, 4'd0); exp_cnt("rst_mid_cnt", 6'd0, 1'b1);
        issue(6, 7); step();
        idle(); rd(6, 0); exp_rd("post_rst", 2'b01, 1'b1, 4'd7); exp_cnt("post_rst_cnt", 6'd1, 1'b0);

        for (int i = 0; i < 5 && q.size() > 0; i++) step();
        step();
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
